// File: rtl/inst_loader_pkg.sv
// ----------------------------------------------------------------------------
// inst_loader_pkg
// Shared definitions for the instruction-image loader:
//   ld_state_t   - loader FSM state encoding (3 bits)
//   LD_HDR_BYTES - bytes per header / data word in the stream
//   word_addr()  - byte address of word k relative to a base address
// ----------------------------------------------------------------------------
package inst_loader_pkg;

    typedef enum logic [2:0] {
        LD_S_HDR  = 3'd0,
        LD_S_DATA = 3'd1,
        LD_S_CSUM = 3'd2,
        LD_S_RUN  = 3'd3,
        LD_S_ERR  = 3'd4
    } ld_state_t;

    localparam int unsigned LD_HDR_BYTES = 4;

    // Word k lives at base + 4*k; wrap is not checked.
    function automatic logic [63:0] word_addr(input logic [63:0] base,
                                              input logic [31:0] k);
        return base + {30'd0, k, 2'b00};
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// ----------------------------------------------------------------------------
// inst_loader_if
// Bundles the loader's byte stream, instruction-SRAM write port and status.
//   master - the loader: consumes in_valid/in_data, drives everything else
//   slave  - the environment: drives the stream, observes SRAM bus/status
// ----------------------------------------------------------------------------
interface inst_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        inst_sram_wen;
    logic [63:0] inst_sram_waddr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_en_toif;
    logic        load_done;
    logic        load_err;
    logic [31:0] words_loaded;

    modport master (
        input  in_valid, in_data,
        output in_ready, inst_sram_wen, inst_sram_waddr, inst_sram_wdata,
               inst_sram_en_toif, load_done, load_err, words_loaded
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, inst_sram_wen, inst_sram_waddr, inst_sram_wdata,
               inst_sram_en_toif, load_done, load_err, words_loaded
    );

endinterface

// File: rtl/inst_loader_ld_byte_asm.sv
// ----------------------------------------------------------------------------
// inst_loader_ld_byte_asm
// Little-endian 4-byte assembler used for both the header count and the
// program words.
//   clk, resetn  - clock, async active-low reset
//   shift_en     - a byte is accepted this cycle
//   byte_in      - the accepted byte
//   word         - assembled word including the current byte (valid with
//                  word_ready)
//   word_ready   - combinational pulse on the 4th byte of a word
// ----------------------------------------------------------------------------
module inst_loader_ld_byte_asm
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [31:0] sh_q;
    logic [1:0]  idx_q;

    // New bytes enter at the top, so after three bytes sh_q[31:8] holds
    // {b2,b1,b0} and the fourth byte completes the word without a extra cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else if (shift_en) begin
            sh_q  <= {byte_in, sh_q[31:8]};
            idx_q <= idx_q + 2'd1;
        end
    end

    assign word       = {byte_in, sh_q[31:8]};
    assign word_ready = shift_en && (idx_q == 2'(LD_HDR_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// ----------------------------------------------------------------------------
// inst_loader
// Loads a program image from a byte stream into instruction SRAM, verifies an
// XOR checksum and then enables instruction fetch.
// Stream (little-endian): 4-byte word count N, N 4-byte words, 1 checksum
// byte equal to the XOR of all preceding bytes.
//   clk, resetn - clock, async active-low reset
//   bus         - inst_loader_if.master: in_valid/in_data/in_ready stream,
//                 inst_sram_wen/waddr/wdata write port, inst_sram_en_toif,
//                 load_done, load_err, words_loaded
// ----------------------------------------------------------------------------
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter logic [63:0]     BASE_ADDR = 64'h0000_0000_0000_0000,
    parameter longint unsigned MAX_WORDS = 4096
) (
    input  logic          clk,
    input  logic          resetn,
    inst_loader_if.master bus
);

    localparam logic [63:0] MAX_W = 64'(MAX_WORDS);

    ld_state_t   state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        hs, asm_shift, asm_ready, data_word;
    logic [31:0] asm_word;
    logic [31:0] hdr_n_q;
    logic [31:0] words_q;
    logic [7:0]  csum_q;
    logic        wen_q;
    logic [63:0] waddr_q;
    logic [31:0] wdata_q;
    logic        en_toif, load_err;

    assign hs        = bus.in_valid && in_ready_q;
    assign asm_shift = hs && (state_q == LD_S_HDR || state_q == LD_S_DATA);
    assign data_word = asm_ready && (state_q == LD_S_DATA);

    inst_loader_ld_byte_asm u_asm (
        .clk        (clk),
        .resetn     (resetn),
        .shift_en   (asm_shift),
        .byte_in    (bus.in_data),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    // State register; in_ready is registered so it stays low through reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= LD_S_HDR;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_S_HDR: begin
                if (asm_ready) begin
                    if ({32'd0, asm_word} > MAX_W) state_d = LD_S_ERR;
                    else if (asm_word == 32'd0)    state_d = LD_S_CSUM;
                    else                           state_d = LD_S_DATA;
                end
            end
            LD_S_DATA: begin
                if (data_word && (words_q + 32'd1 == hdr_n_q)) state_d = LD_S_CSUM;
            end
            LD_S_CSUM: begin
                if (hs) state_d = (bus.in_data == csum_q) ? LD_S_RUN : LD_S_ERR;
            end
            default: state_d = state_q;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready_d = 1'b0;
        case (state_d)
            LD_S_HDR, LD_S_DATA, LD_S_CSUM: in_ready_d = 1'b1;
            default:                        in_ready_d = 1'b0;
        endcase
        en_toif  = (state_q == LD_S_RUN);
        load_err = (state_q == LD_S_ERR);
    end

    // Header count, checksum, word counter and SRAM write port.
    // waddr/wdata hold between strobes; wen is a single-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hdr_n_q <= '0;
            csum_q  <= '0;
            words_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= data_word;
            if (asm_shift) csum_q <= csum_q ^ bus.in_data;
            if (asm_ready && state_q == LD_S_HDR) hdr_n_q <= asm_word;
            if (data_word) begin
                waddr_q <= word_addr(BASE_ADDR, words_q);
                wdata_q <= asm_word;
                words_q <= words_q + 32'd1;
            end
        end
    end

    assign bus.in_ready          = in_ready_q;
    assign bus.inst_sram_wen     = wen_q;
    assign bus.inst_sram_waddr   = waddr_q;
    assign bus.inst_sram_wdata   = wdata_q;
    assign bus.inst_sram_en_toif = en_toif;
    assign bus.load_done         = en_toif;
    assign bus.load_err          = load_err;
    assign bus.words_loaded      = words_q;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream feeder of the CPU top's instruction SRAM write port and fetch-enable.
- Accepts a byte stream (valid/ready) carrying a program image and writes it word by word into instruction SRAM through inst_sram_wen / inst_sram_waddr / inst_sram_wdata.
- Checks an XOR checksum, then raises inst_sram_en_toif so the IF stage starts fetching.
- Holds the CPU in no-fetch until a complete, valid image has been loaded.

Parameters:
- BASE_ADDR, 64'h0000_0000_0000_0000: byte address of word 0.
- MAX_WORDS, 4096: largest accepted word count. Range 1..2^31.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte. A transfer occurs when in_valid && in_ready at the clk rising edge.
- inst_sram_wen  out  1  one-cycle SRAM write strobe.
- inst_sram_waddr  out  64  write byte address. Word aligned.
- inst_sram_wdata  out  32  write data.
- inst_sram_en_toif  out  1  fetch enable to IF stage. Sticky high.
- load_done  out  1  image accepted. Equals inst_sram_en_toif.
- load_err  out  1  sticky error flag (oversize image or checksum mismatch).
- words_loaded  out  32  count of words written so far.

Behaviour:
- Reset (async assert, sync release):
  - State = S_HDR.
  - All outputs 0, except in_ready = 1 one cycle after release.
  - Internal byte index, word count, checksum accumulator and shift register are all cleared.
- Stream format, all little-endian:
  - 4-byte word count N.
  - N words of 4 bytes each.
  - 1 checksum byte. Its value equals the XOR of every preceding byte, header included.
- States:
  - S_HDR:
    - Accept 4 bytes into N.
    - After the 4th byte: if N > MAX_WORDS, go to S_ERR. If N == 0, go to S_CSUM. Otherwise go to S_DATA.
  - S_DATA:
    - Shift in bytes.
    - On the 4th byte of word k, register waddr = BASE_ADDR + 4*k and wdata = assembled word. Assert inst_sram_wen for exactly the next cycle.
    - words_loaded increments in that same cycle.
    - After word N-1, go to S_CSUM.
  - S_CSUM:
    - Accept 1 byte.
    - If the byte equals the accumulator, go to S_RUN. Otherwise go to S_ERR.
  - S_RUN:
    - in_ready = 0.
    - inst_sram_en_toif = load_done = 1, asserted the cycle after the checksum handshake.
    - Held until reset.
  - S_ERR:
    - in_ready = 0, load_err = 1, inst_sram_en_toif = 0.
    - Held until reset.
- in_ready is 1 in S_HDR, S_DATA and S_CSUM, including cycles where wen is pulsing.
  - Back-to-back bytes every cycle are supported with no bubbles.
  - A word's write never collides with the next word's write, because the minimum spacing is 4 cycles.
- Bytes are consumed only on handshake. A byte with in_valid=0 is ignored; gaps of any length are allowed.
- The checksum accumulator XORs every accepted byte before the checksum byte.
- Word index k and address arithmetic use 64-bit unsigned math; wrap is not checked (BASE_ADDR + 4*MAX_WORDS must fit).
- inst_sram_waddr and inst_sram_wdata hold their last value between strobes. They are meaningful only while wen = 1.
- Reset mid-load clears everything immediately:
  - en_toif drops asynchronously.
  - Partially loaded SRAM contents are not erased; the next load overwrites them.
- Bytes presented in S_RUN or S_ERR are not accepted, because in_ready = 0.

Decomposition:
- Shared header mycpu.h gets:
  - State encodings LD_S_HDR, LD_S_DATA, LD_S_CSUM, LD_S_RUN, LD_S_ERR (3 bits).
  - `LD_HDR_BYTES 4.
- One natural sub-module: ld_byte_asm.
  - 4-byte little-endian shift/assemble register with a 2-bit byte index and a word_ready pulse.
  - Reused for both the header and data words.
- The FSM, address generation, checksum and counters stay in inst_loader.

Test Plan:
- Minimal program, contiguous bytes: stream 01 00 00 00 | 93 00 10 00 | 82.
  - Required: one wen pulse with waddr=0x0 and wdata=0x00100093.
  - words_loaded=1.
  - en_toif=1 one cycle after the 0x82 handshake.
  - load_err=0, in_ready=0 afterwards.
- Three words with random in_valid gaps (0-5 idle cycles), correct checksum.
  - Required: wen at waddr 0x0, 0x4, 0x8 with matching data and exactly three pulses.
  - en_toif set.
- Bad checksum: stream as in the first scenario but last byte 0x83.
  - Required: the word write still occurs.
  - load_err=1, en_toif stays 0, in_ready=0.
- Oversize header, MAX_WORDS=4: header 05 00 00 00.
  - Required: load_err=1 after the 4th byte, no wen pulse ever, no further bytes accepted.
- Empty image: header 00 00 00 00 then checksum 00.
  - Required: no wen, words_loaded=0, en_toif=1.
- Reset mid-load: drop resetn after 6 bytes of the first scenario's stream, release, then replay the full stream.
  - Required: all outputs 0 during reset, with no wen pulse before the replay.
  - The replay completes exactly as in the first scenario.
